// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receiver: oversampling ratio,
// parity-mode encoding, receiver FSM states and the bit-vote helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // 2-of-3 majority over the samples taken at ticks 7, 8 and 9 of a bit.
  function automatic logic vote3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Valid/ready stream carrying the FIFO head word {frame_err, parity_err, data}.
interface uart_rx_core_if #(
  parameter int W = 10
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words; reports a dropped push when full.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             drop_o,
  uart_rx_core_if.master   rd
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full     = (count == FULL_CNT);
  assign rd.valid = (count != '0);
  assign pop      = rd.valid & rd.ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en    = push_i & (~full | pop);
  assign drop_o   = push_i & full & ~pop;
  assign rd.data  = rd.valid ? mem[rd_ptr] : '0;

  // NOTE: storage is deliberately not reset; the valid-gated read covers the empty case.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampling UART receiver: synchroniser, prescaler, frame FSM with
// majority voting, error/break detection and an output FIFO.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 two_stop_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 break_o,
  input  logic                 clear_err_i,
  output logic                 busy_o
);
  localparam int WORD_W = DATA_BITS + 2;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS);

  logic                 rx_meta, rx_sync, rx_prev;
  rx_state_e            state;
  logic [DIV_WIDTH-1:0] presc;
  logic [TICK_W-1:0]    tick_cnt;
  logic [1:0]           samples;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  parity_mode_e         par_mode;
  logic                 two_stop_q, stop_idx;
  logic                 frame_err_q, parity_err_q, all_low;
  logic                 push_q, brk_set_q, busy_q;
  logic [WORD_W-1:0]    push_word;
  logic                 overrun_q, break_q, drop;
  logic                 tick, decide, vote, has_parity, exp_par, last_stop;

  assign tick       = (presc == baud_div_i);
  assign decide     = tick && (tick_cnt == TICK_W'(9));
  assign vote       = vote3({samples, rx_sync});
  assign has_parity = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
  assign exp_par    = (^shreg) ^ (par_mode == PAR_ODD);
  assign last_stop  = ~two_stop_q | stop_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      presc        <= '0;
      tick_cnt     <= '0;
      samples      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_mode     <= PAR_NONE;
      two_stop_q   <= 1'b0;
      stop_idx     <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      all_low      <= 1'b0;
      push_q       <= 1'b0;
      brk_set_q    <= 1'b0;
      busy_q       <= 1'b0;
      push_word    <= '0;
    end else begin
      push_q    <= 1'b0;
      brk_set_q <= 1'b0;
      if (state == ST_IDLE) begin
        presc    <= '0;
        tick_cnt <= '0;
        if (rx_prev && !rx_sync) begin
          state      <= ST_START;
          busy_q     <= 1'b1;
          par_mode   <= parity_mode_e'(parity_mode_i);
          two_stop_q <= two_stop_i;
        end
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          tick_cnt <= tick_cnt + 1'b1;
          if (tick_cnt == TICK_W'(7)) samples[1] <= rx_sync;
          if (tick_cnt == TICK_W'(8)) samples[0] <= rx_sync;
        end
        // Decisions land mid-bit; the tick counter keeps running to the next bit.
        if (decide) begin
          unique case (state)
            ST_START: begin
              if (vote) begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
              end else begin
                state        <= ST_DATA;
                bit_idx      <= '0;
                stop_idx     <= 1'b0;
                frame_err_q  <= 1'b0;
                parity_err_q <= 1'b0;
                all_low      <= 1'b1;
              end
            end
            ST_DATA: begin
              shreg   <= {vote, shreg[DATA_BITS-1:1]};
              all_low <= all_low & ~vote;
              if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                state <= has_parity ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
            ST_PARITY: begin
              parity_err_q <= (vote != exp_par);
              all_low      <= all_low & ~vote;
              state        <= ST_STOP;
            end
            ST_STOP: begin
              if (last_stop) begin
                push_q    <= 1'b1;
                push_word <= {frame_err_q | ~vote, parity_err_q, shreg};
                brk_set_q <= stop_idx ? all_low : (all_low & ~vote);
                state     <= ST_IDLE;
                busy_q    <= 1'b0;
              end else begin
                frame_err_q <= ~vote;
                all_low     <= all_low & ~vote;
                stop_idx    <= 1'b1;
              end
            end
            default: begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Sticky flags: a same-cycle set beats clear_err_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      if (drop)             overrun_q <= 1'b1;
      else if (clear_err_i) overrun_q <= 1'b0;
      if (brk_set_q)        break_q   <= 1'b1;
      else if (clear_err_i) break_q   <= 1'b0;
    end
  end

  uart_rx_core_if #(.W(WORD_W)) head_if ();

  uart_rx_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_q),
    .wdata_i(push_word),
    .drop_o (drop),
    .rd     (head_if.master)
  );

  assign head_if.ready = rx_ready_i;
  assign rx_valid_o    = head_if.valid;
  assign rx_data_o     = head_if.data[DATA_BITS-1:0];
  assign parity_err_o  = head_if.data[DATA_BITS];
  assign frame_err_o   = head_if.data[DATA_BITS+1];
  assign overrun_o     = overrun_q;
  assign break_o       = break_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized frames
// checked against a frame-level reference model (expected-word queue).
module tb_uart_rx_core;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_WIDTH  = 16;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } word_t;

  logic                 clk_i       = 1'b0;
  logic                 rst_ni      = 1'b0;
  logic                 rx_i        = 1'b1;
  logic [DIV_WIDTH-1:0] baud_div    = '0;
  logic [1:0]           parity_mode = 2'b00;
  logic                 two_stop    = 1'b0;
  logic                 clear_err   = 1'b0;
  logic [7:0]           rx_data;
  logic                 frame_err, parity_err, overrun, break_s, busy;

  uart_rx_core_if #(.W(10)) head_if ();

  assign head_if.data = {frame_err, parity_err, rx_data};

  uart_rx_core #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .baud_div_i   (baud_div),
    .parity_mode_i(parity_mode),
    .two_stop_i   (two_stop),
    .rx_data_o    (rx_data),
    .rx_valid_o   (head_if.valid),
    .rx_ready_i   (head_if.ready),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err),
    .overrun_o    (overrun),
    .break_o      (break_s),
    .clear_err_i  (clear_err),
    .busy_o       (busy)
  );

  // 25 ns clock period.
  initial forever begin
    #13 clk_i = 1'b1;
    #12 clk_i = 1'b0;
  end

  int    checks   = 0;
  int    failures = 0;
  word_t model_q[$];
  logic  exp_overrun = 1'b0;
  logic  exp_break   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_clks();
    return 16 * (int'(baud_div) + 1);
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Drive one frame on the line and record what the receiver must deliver.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] pmode,
                            input logic pbit, input logic two,
                            input logic s1, input logic s2);
    logic  line[$];
    logic  has_par;
    logic  good_par;
    word_t w;
    has_par     = (pmode == 2'b01) || (pmode == 2'b10);
    parity_mode = pmode;
    two_stop    = two;
    line.push_back(1'b0);
    for (int i = 0; i < 8; i++) line.push_back(data[i]);
    if (has_par) line.push_back(pbit);
    line.push_back(s1);
    if (two) line.push_back(s2);
    foreach (line[i]) begin
      rx_i = line[i];
      wait_clks(bit_clks());
    end
    rx_i = 1'b1;
    wait_clks(4);
    good_par     = 1'(($countones(data) % 2)) ^ (pmode == 2'b10);
    w.data       = data;
    w.parity_err = has_par && (pbit != good_par);
    w.frame_err  = !s1 || (two && !s2);
    if (data == 8'h00 && (!has_par || !pbit) && !s1) exp_break = 1'b1;
    if (model_q.size() == FIFO_DEPTH) exp_overrun = 1'b1;
    else model_q.push_back(w);
  endtask

  task automatic pop_check(input string tag);
    word_t w;
    if (model_q.size() == 0) begin
      check({tag, "_empty"}, 32'(head_if.valid), 32'd0);
      return;
    end
    w = model_q.pop_front();
    check({tag, "_valid"}, 32'(head_if.valid), 32'd1);
    check({tag, "_data"},  32'(rx_data),       32'(w.data));
    check({tag, "_ferr"},  32'(frame_err),     32'(w.frame_err));
    check({tag, "_perr"},  32'(parity_err),    32'(w.parity_err));
    head_if.ready = 1'b1;
    @(negedge clk_i);
    head_if.ready = 1'b0;
  endtask

  task automatic clear_sticky();
    clear_err = 1'b1;
    @(negedge clk_i);
    clear_err   = 1'b0;
    exp_break   = 1'b0;
    exp_overrun = 1'b0;
  endtask

  initial begin
    logic [7:0] rdata;
    logic [1:0] rmode;
    logic       rpbit, rtwo, rs1, rs2;
    head_if.ready = 1'b0;

    // Reset state
    wait_clks(3);
    check("rst_valid",   32'(head_if.valid), 32'd0);
    check("rst_data",    32'(rx_data),       32'd0);
    check("rst_busy",    32'(busy),          32'd0);
    check("rst_overrun", 32'(overrun),       32'd0);
    check("rst_break",   32'(break_s),       32'd0);
    rst_ni = 1'b1;
    wait_clks(5);

    // 8N1 0x41
    send_frame(8'h41, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    pop_check("8n1_41");
    check("8n1_41_drained", 32'(head_if.valid), 32'd0);

    // Even parity, 0x03 with wrong parity bit 1
    send_frame(8'h03, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
    pop_check("even_03");

    // Framing error, then break
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check("ferr_55");
    check("ferr_55_nobreak", 32'(break_s), 32'd0);
    send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check("break_00");
    check("break_set", 32'(break_s), 32'(exp_break));
    wait_clks(20);
    check("break_sticky", 32'(break_s), 32'd1);
    clear_sticky();
    check("break_cleared", 32'(break_s), 32'd0);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_set", 32'(overrun), 32'(exp_overrun));
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_pop%0d", i));
    check("ovr_drained", 32'(head_if.valid), 32'd0);
    check("ovr_sticky",  32'(overrun),       32'd1);
    clear_sticky();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Three-clock glitch must not produce a word
    rx_i = 1'b0;
    wait_clks(3);
    rx_i = 1'b1;
    wait_clks(2);
    check("glitch_busy", 32'(busy), 32'd1);
    wait_clks(bit_clks());
    check("glitch_idle",  32'(busy),          32'd0);
    check("glitch_nopush", 32'(head_if.valid), 32'd0);

    // Randomized frames: prescaler, parity mode, stop bits and error injection
    for (int n = 0; n < 12; n++) begin
      baud_div = DIV_WIDTH'($urandom_range(0, 2));
      rdata    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) rdata = 8'h00;
      rmode    = 2'($urandom_range(0, 3));
      rtwo     = 1'($urandom_range(0, 1));
      rs1      = ($urandom_range(0, 3) != 0);
      rs2      = ($urandom_range(0, 3) != 0);
      rpbit    = 1'(($countones(rdata) % 2)) ^ (rmode == 2'b10);
      if ($urandom_range(0, 3) == 0) rpbit = ~rpbit;
      send_frame(rdata, rmode, rpbit, rtwo, rs1, rs2);
      pop_check($sformatf("rand%0d", n));
      check($sformatf("rand%0d_break", n),   32'(break_s), 32'(exp_break));
      check($sformatf("rand%0d_overrun", n), 32'(overrun), 32'(exp_overrun));
      clear_sticky();
    end
    baud_div = '0;

    // Reset in the middle of a frame
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    rx_i = 1'b0;
    wait_clks(bit_clks());
    rx_i = 1'b0;
    wait_clks(bit_clks());
    rx_i = 1'b0;
    wait_clks(bit_clks());
    rx_i = 1'b1;
    wait_clks(bit_clks() / 2);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(head_if.valid), 32'd0);
    check("mid_rst_data",  32'(rx_data),       32'd0);
    check("mid_rst_busy",  32'(busy),          32'd0);
    model_q.delete();
    exp_break   = 1'b0;
    exp_overrun = 1'b0;
    @(negedge clk_i);
    wait_clks(3);
    rst_ni = 1'b1;
    wait_clks(2 * bit_clks());
    check("post_rst_nopush", 32'(head_if.valid), 32'd0);
    check("post_rst_idle",   32'(busy),          32'd0);
    send_frame(8'hA4, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    pop_check("post_rst_a4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
